// File: rtl/epmp_bus_ctrl.sv
// -----------------------------------------------------------------------------
// epmp_bus_ctrl
//   External-bus cycle sequencer for the EPMP datapath. Turns one-cycle
//   read/write request pulses from the control unit into timed external bus
//   cycles: address/data setup, strobe with READY wait states, one hold cycle.
//
// Parameters
//   SETUP_CYC   address/data setup cycles before the strobe (1..15)
//   TIMEOUT     strobe cycles with ext_ready low before an abort (1..15)
//
// Build option
//   EPMP_BUS_TIMEOUT_EN   when defined, a strobe that sees ext_ready low on its
//                         TIMEOUT-th cycle aborts through ERR (bus_err pulse).
//                         When undefined the strobe waits forever and bus_err
//                         stays 0.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   mem_rd_req   read request pulse (sampled only when idle)
//   mem_wr_req   write request pulse (sampled only when idle)
//   ext_ready    memory ready, 1 = cycle may complete
//   mem_busy     1 while a bus cycle is in progress
//   mem_done     one-cycle pulse at the end of a bus cycle
//   bus_err      one-cycle pulse on timeout abort, together with mem_done
//   ext_rd_n     active-low read strobe
//   ext_wr_n     active-low write strobe
//   MAR_XB_En    MAR drives the external address bus
//   MDR_XB_Load  MDR captures D at this posedge (combinational, read strobe)
//   MDR_XB_En    MDR drives the external data bus
// -----------------------------------------------------------------------------
module epmp_bus_ctrl #(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_rd_req,
    input  logic mem_wr_req,
    input  logic ext_ready,
    output logic mem_busy,
    output logic mem_done,
    output logic bus_err,
    output logic ext_rd_n,
    output logic ext_wr_n,
    output logic MAR_XB_En,
    output logic MDR_XB_Load,
    output logic MDR_XB_En
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        RD_STRB = 3'd2,
        WR_STRB = 3'd3,
        HOLD    = 3'd4,
        ERR     = 3'd5
    } state_t;

`ifdef EPMP_BUS_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [3:0] TO_LAST    = 4'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       is_wr_q, is_wr_d;
    logic [3:0] setup_cnt_q, setup_cnt_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;

    // Moore outputs are registered: they are decoded from the next state and
    // loaded together with it, so they change cleanly on the clock edge.
    logic busy_q, done_q, err_q, rd_n_q, wr_n_q, mar_en_q, mdr_en_q;
    logic busy_d, done_d, err_d, rd_n_d, wr_n_d, mar_en_d, mdr_en_d;

    // Wait counter equals (strobe cycles so far - 1) while ready is low, so
    // it reaching TO_LAST marks the TIMEOUT-th strobe cycle.
    logic timeout_hit;
    assign timeout_hit = TO_EN && (wait_cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        setup_cnt_d = setup_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        unique case (state_q)
            IDLE: begin
                // Read has priority; a simultaneous write is dropped.
                if (mem_rd_req || mem_wr_req) begin
                    state_d     = SETUP;
                    is_wr_d     = !mem_rd_req;
                    setup_cnt_d = 4'd0;
                end
            end
            SETUP: begin
                if (setup_cnt_q == SETUP_LAST) begin
                    state_d    = is_wr_q ? WR_STRB : RD_STRB;
                    wait_cnt_d = 4'd0;
                end else begin
                    setup_cnt_d = setup_cnt_q + 4'd1;
                end
            end
            RD_STRB, WR_STRB: begin
                if (ext_ready) begin
                    state_d = HOLD;
                end else if (timeout_hit) begin
                    state_d = ERR;
                end else if (wait_cnt_q != 4'hF) begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            HOLD:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == HOLD) || (state_d == ERR);
        err_d    = TO_EN && (state_d == ERR);
        rd_n_d   = (state_d != RD_STRB);
        wr_n_d   = (state_d != WR_STRB);
        mar_en_d = (state_d == SETUP) || (state_d == RD_STRB) ||
                   (state_d == WR_STRB) || (state_d == HOLD);
        mdr_en_d = is_wr_d && ((state_d == SETUP) || (state_d == WR_STRB) ||
                               (state_d == HOLD));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            setup_cnt_q <= 4'd0;
            wait_cnt_q  <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            mar_en_q    <= 1'b0;
            mdr_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            setup_cnt_q <= setup_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            mar_en_q    <= mar_en_d;
            mdr_en_q    <= mdr_en_d;
        end
    end

    assign mem_busy  = busy_q;
    assign mem_done  = done_q;
    assign bus_err   = err_q;
    assign ext_rd_n  = rd_n_q;
    assign ext_wr_n  = wr_n_q;
    assign MAR_XB_En = mar_en_q;
    assign MDR_XB_En = mdr_en_q;

    // Load follows ready within the read strobe cycle; suppressed while reset
    // is asserted so an interrupted read never captures data.
    assign MDR_XB_Load = (state_q == RD_STRB) && ext_ready && !rst;

endmodule

// File: tb/tb_epmp_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_epmp_bus_ctrl
//   Directed testbench for epmp_bus_ctrl. A transaction-level model tracks
//   each bus cycle by its age since acceptance and predicts every output on
//   every cycle; directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_epmp_bus_ctrl;

    localparam int S_CYC = 1;
    localparam int TO    = 15;
`ifdef EPMP_BUS_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_rd_req = 1'b0;
    logic mem_wr_req = 1'b0;
    logic ext_ready = 1'b0;
    logic mem_busy, mem_done, bus_err, ext_rd_n, ext_wr_n;
    logic MAR_XB_En, MDR_XB_Load, MDR_XB_En;
    logic [7:0] d_bus = 8'h00;
    logic [7:0] mdr = 8'h00;

    int n_pass = 0;
    int n_checks = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    epmp_bus_ctrl #(.SETUP_CYC(S_CYC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .ext_ready(ext_ready),
        .mem_busy(mem_busy), .mem_done(mem_done), .bus_err(bus_err),
        .ext_rd_n(ext_rd_n), .ext_wr_n(ext_wr_n), .MAR_XB_En(MAR_XB_En),
        .MDR_XB_Load(MDR_XB_Load), .MDR_XB_En(MDR_XB_En)
    );

    // Stand-in MDR capturing the data bus when told to.
    always @(posedge clk) if (MDR_XB_Load) mdr <= d_bus;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- transaction model ----------------
    // age = cycles since the request was accepted (1 = first setup cycle),
    // end_age = age of the completion cycle once known (0 = still strobing).
    bit m_valid = 0;
    bit m_busy = 0;
    bit m_write = 0;
    bit m_err = 0;
    int m_age = 0;
    int m_end = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1;
            m_busy  = 0;
        end else if (m_valid) begin
            if (!m_busy) begin
                if (mem_rd_req || mem_wr_req) begin
                    m_busy = 1; m_write = !mem_rd_req; m_age = 1; m_end = 0; m_err = 0;
                end
            end else if (m_age == m_end) begin
                m_busy = 0;
            end else begin
                if (m_age > S_CYC && m_end == 0) begin
                    if (ext_ready) begin
                        m_end = m_age + 1; m_err = 0;
                    end else if (TO_ON && (m_age - S_CYC) == TO) begin
                        m_end = m_age + 1; m_err = 1;
                    end
                end
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        bit setup, strobe, done;
        logic [7:0] exp, act;
        if (m_valid) begin
            setup  = m_busy && m_age <= S_CYC;
            strobe = m_busy && m_age > S_CYC && m_end == 0;
            done   = m_busy && m_end != 0 && m_age == m_end;
            exp[7] = m_busy;
            exp[6] = done;
            exp[5] = done && m_err;
            exp[4] = !(strobe && !m_write);
            exp[3] = !(strobe && m_write);
            exp[2] = setup || strobe || (done && !m_err);
            exp[1] = strobe && !m_write && ext_ready && !rst;
            exp[0] = m_write && (setup || strobe || (done && !m_err));
            act = {mem_busy, mem_done, bus_err, ext_rd_n, ext_wr_n,
                   MAR_XB_En, MDR_XB_Load, MDR_XB_En};
            chk("cycle busy/done/err/rdn/wrn/mar/load/mdren", 32'(act), 32'(exp));
            if (mem_done === 1'b1) done_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int base, strobes, got;
        logic err_seen;

        // Reset
        repeat (3) next_cyc();
        mid();
        chk("reset busy", 32'(mem_busy), 32'd0);
        chk("reset rd_n/wr_n", 32'({ext_rd_n, ext_wr_n}), 32'b11);
        chk("reset enables", 32'({MAR_XB_En, MDR_XB_En, mem_done, bus_err}), 32'd0);
        rst = 1'b0;

        // 1: read, zero wait, D = A5
        ext_ready = 1'b1; d_bus = 8'hA5;
        next_cyc(); mem_rd_req = 1'b1;                              // c0
        next_cyc(); mem_rd_req = 1'b0; mid();                       // c1
        chk("t1 c1 busy", 32'(mem_busy), 32'd1);
        chk("t1 c1 rd_n", 32'(ext_rd_n), 32'd1);
        next_cyc(); mid();                                          // c2
        chk("t1 c2 rd_n", 32'(ext_rd_n), 32'd0);
        chk("t1 c2 load", 32'(MDR_XB_Load), 32'd1);
        next_cyc(); mid();                                          // c3
        chk("t1 c3 done", 32'(mem_done), 32'd1);
        chk("t1 c3 rd_n", 32'(ext_rd_n), 32'd1);
        next_cyc(); mid();                                          // c4
        chk("t1 c4 busy", 32'(mem_busy), 32'd0);
        chk("t1 mdr", 32'(mdr), 32'hA5);
        $display("txn read zero-wait mdr=%0h", mdr);

        // 2: write, three wait states
        ext_ready = 1'b0;
        next_cyc(); mem_wr_req = 1'b1;                              // c0
        next_cyc(); mem_wr_req = 1'b0; mid();                       // c1
        chk("t2 c1 mdr_en", 32'(MDR_XB_En), 32'd1);
        chk("t2 c1 wr_n", 32'(ext_wr_n), 32'd1);
        for (int c = 2; c <= 4; c++) begin
            next_cyc(); mid();
            chk("t2 waits wr_n", 32'(ext_wr_n), 32'd0);
        end
        next_cyc(); ext_ready = 1'b1; mid();                        // c5
        chk("t2 c5 wr_n", 32'(ext_wr_n), 32'd0);
        next_cyc(); mid();                                          // c6
        chk("t2 c6 done+mdr_en", 32'({mem_done, MDR_XB_En, ext_wr_n}), 32'b111);
        next_cyc(); mid();                                          // c7
        chk("t2 c7 busy", 32'(mem_busy), 32'd0);
        $display("txn write 3-wait done");

        // 3: simultaneous requests -> read only
        next_cyc(); mem_rd_req = 1'b1; mem_wr_req = 1'b1;
        next_cyc(); mem_rd_req = 1'b0; mem_wr_req = 1'b0;
        next_cyc(); mid();                                          // c2
        chk("t3 strobes rd_n/wr_n", 32'({ext_rd_n, ext_wr_n}), 32'b01);
        next_cyc(); next_cyc(); mid();
        chk("t3 idle", 32'(mem_busy), 32'd0);
        $display("txn rd+wr collision -> read");

        // 4: request while busy is ignored
        ext_ready = 1'b0;
        base = done_cnt;
        next_cyc(); mem_rd_req = 1'b1;                              // c0
        next_cyc(); mem_rd_req = 1'b0;                              // c1
        next_cyc(); mem_rd_req = 1'b1;                              // c2 (busy)
        next_cyc(); mem_rd_req = 1'b0;                              // c3
        next_cyc(); ext_ready = 1'b1;                               // c4
        repeat (6) next_cyc();
        mid();
        chk("t4 single done", 32'(done_cnt - base), 32'd1);
        chk("t4 idle", 32'(mem_busy), 32'd0);
        $display("txn read with ignored busy request, dones=%0d", done_cnt - base);

        // 5: ready never comes
        ext_ready = 1'b0;
        next_cyc(); mem_rd_req = 1'b1;
        next_cyc(); mem_rd_req = 1'b0;
        if (TO_ON) begin
            strobes = 0; got = 0; err_seen = 1'b0;
            for (int i = 0; i < 40 && got == 0; i++) begin
                next_cyc(); mid();
                if (ext_rd_n === 1'b0) strobes++;
                if (mem_done === 1'b1) begin
                    got = 1; err_seen = bus_err;
                end
            end
            chk("t5 timeout reached", 32'(got), 32'd1);
            chk("t5 strobe cycles", 32'(strobes), 32'(TO));
            chk("t5 bus_err", 32'(err_seen), 32'd1);
            next_cyc(); mid();
            chk("t5 idle after err", 32'(mem_busy), 32'd0);
            $display("txn read timeout strobes=%0d", strobes);
            // start a fresh read and park it in the strobe for test 6
            next_cyc(); mem_rd_req = 1'b1;
            next_cyc(); mem_rd_req = 1'b0;
            next_cyc();
        end else begin
            repeat (100) next_cyc();
            mid();
            chk("t5 still strobing", 32'(ext_rd_n), 32'd0);
            chk("t5 no bus_err", 32'(bus_err), 32'd0);
            $display("txn read hung 100 cycles, no timeout");
        end

        // 6: reset in the middle of a read strobe
        mid();
        chk("t6 in strobe", 32'(ext_rd_n), 32'd0);
        next_cyc(); rst = 1'b1;
        next_cyc(); rst = 1'b0; mid();
        chk("t6 released", 32'({ext_rd_n, mem_busy, mem_done, MDR_XB_Load}), 32'b1000);
        $display("txn reset during read strobe");

        next_cyc(); next_cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
